// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer for one RV32 R-type / I-type ALU instruction:
// accept, decode, read operands, execute, write back, then wait for the next.
module exec_sequencer #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [RA_W-1:0] rf_rs1_addr,
    output logic [RA_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [7:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_AND  = 8'd2;
    localparam logic [7:0] OP_OR   = 8'd3;
    localparam logic [7:0] OP_XOR  = 8'd4;
    localparam logic [7:0] OP_SLL  = 8'd5;
    localparam logic [7:0] OP_SLT  = 8'd6;
    localparam logic [7:0] OP_SLTU = 8'd7;
    localparam logic [7:0] OP_SRA  = 8'd8;
    localparam logic [7:0] OP_SRL  = 8'd9;

    state_t            r_state;
    logic [31:0]       r_instr;
    logic [RA_W-1:0]   r_rd;
    logic              r_isRType;
    logic              r_isShift;
    logic [7:0]        r_aluOp;
    logic [XLEN-1:0]   r_aluA;
    logic [XLEN-1:0]   r_aluB;
    logic              r_rfWe;
    logic [RA_W-1:0]   r_rfWaddr;
    logic [XLEN-1:0]   r_rfWdata;
    logic              r_done;
    logic              r_illegal;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic              w_legal;
    logic              w_isR;
    logic              w_isShift;
    logic [7:0]        w_aluOp;
    logic [XLEN-1:0]   w_immSext;
    logic [XLEN-1:0]   w_immShamt;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7   = r_instr[31:25];
    assign w_immSext  = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_immShamt = {{(XLEN-5){1'b0}}, r_instr[24:20]};

    // Classify the latched instruction; only R-type and OP-IMM with valid funct fields are legal.
    always_comb begin
        w_legal   = 1'b0;
        w_isR     = 1'b0;
        w_isShift = 1'b0;
        w_aluOp   = OP_ADD;
        if (w_opcode == OPC_RTYPE) begin
            w_isR   = 1'b1;
            w_legal = (w_funct7 == F7_BASE) ||
                      ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            case (w_funct3)
                3'b000:  w_aluOp = (w_funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                3'b001:  w_aluOp = OP_SLL;
                3'b010:  w_aluOp = OP_SLT;
                3'b011:  w_aluOp = OP_SLTU;
                3'b100:  w_aluOp = OP_XOR;
                3'b101:  w_aluOp = (w_funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                3'b110:  w_aluOp = OP_OR;
                default: w_aluOp = OP_AND;
            endcase
        end else if (w_opcode == OPC_ITYPE) begin
            case (w_funct3)
                3'b000: begin w_aluOp = OP_ADD;  w_legal = 1'b1; end
                3'b010: begin w_aluOp = OP_SLT;  w_legal = 1'b1; end
                3'b011: begin w_aluOp = OP_SLTU; w_legal = 1'b1; end
                3'b100: begin w_aluOp = OP_XOR;  w_legal = 1'b1; end
                3'b110: begin w_aluOp = OP_OR;   w_legal = 1'b1; end
                3'b111: begin w_aluOp = OP_AND;  w_legal = 1'b1; end
                3'b001: begin
                    w_aluOp   = OP_SLL;
                    w_isShift = 1'b1;
                    w_legal   = (w_funct7 == F7_BASE);
                end
                default: begin
                    w_isShift = 1'b1;
                    w_aluOp   = (w_funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                    w_legal   = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                end
            endcase
        end
    end

    // Sequencer: every output is registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_rd      <= '0;
            r_isRType <= 1'b0;
            r_isShift <= 1'b0;
            r_aluOp   <= '0;
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_rfWe    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_aluOp   <= w_aluOp;
                        r_rd      <= RA_W'(r_instr[11:7]);
                        r_isRType <= w_isR;
                        r_isShift <= w_isShift;
                        r_state   <= S_READ;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_aluA  <= rf_rs1_data;
                    r_aluB  <= r_isRType ? rf_rs2_data : (r_isShift ? w_immShamt : w_immSext);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Capture the result here so rf_we/done line up with WB.
                    r_rfWdata <= alu_result;
                    r_rfWaddr <= r_rd;
                    r_rfWe    <= (r_rd != '0);
                    r_done    <= 1'b1;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE) & ~rst;
    assign busy        = (r_state != S_IDLE);
    assign rf_rs1_addr = RA_W'(r_instr[19:15]);
    assign rf_rs2_addr = RA_W'(r_instr[24:20]);
    assign rf_we       = r_rfWe;
    assign rf_waddr    = r_rfWaddr;
    assign rf_wdata    = r_rfWdata;
    assign alu_op      = r_aluOp;
    assign alu_a       = r_aluA;
    assign alu_b       = r_aluB;
    assign done        = r_done;
    assign illegal     = r_illegal;

endmodule
